// File: rtl/gain_step_control.sv
// Button-driven gain stepper: turns debounced up/down levels into signed dB gain
// requests on a fixed grid, with auto-repeat on hold and busy-aware set strobes.
module gain_step_control #(
    parameter int W                 = 8,
    parameter int GAIN_MIN          = -16,
    parameter int GAIN_MAX          = 44,
    parameter int GAIN_STEP         = 4,
    parameter int GAIN_RESET        = 0,
    parameter int WRAP              = 1,
    parameter int REPEAT_DELAY_CYC  = 10000000,
    parameter int REPEAT_PERIOD_CYC = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_i,
    input  logic         down_i,
    input  logic         busy_i,
    output logic [W-1:0] gain_dB_o,
    output logic         set_gain_o,
    output logic         at_min_o,
    output logic         at_max_o
);

    localparam int CNT_MAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ? REPEAT_DELAY_CYC
                                                                    : REPEAT_PERIOD_CYC;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY_CYC - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD_CYC - 1);

    localparam logic signed [W:0]   MIN_E   = (W+1)'(GAIN_MIN);
    localparam logic signed [W:0]   MAX_E   = (W+1)'(GAIN_MAX);
    localparam logic signed [W:0]   STEP_E  = (W+1)'(GAIN_STEP);
    localparam logic        [W-1:0] RESET_G = W'(GAIN_RESET);
    localparam logic        [W-1:0] MIN_G   = W'(GAIN_MIN);
    localparam logic        [W-1:0] MAX_G   = W'(GAIN_MAX);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dir_up_q, dir_up_d;
    logic            up_q, down_q;
    logic            hist_vld_q;
    logic [W-1:0]    gain_q, gain_d;
    logic            pending_q, pending_d;
    logic            set_q, set_d;

    logic            up_edge, down_edge, both, active_held;
    logic            step, step_up, changed, pulse_ok;
    logic signed [W:0] g_ext, g_inc, g_dec, g_next;

    // History is only trusted after one post-reset clock, so a button held through
    // reset never looks like a fresh press.
    assign up_edge     = hist_vld_q & up_i   & ~up_q;
    assign down_edge   = hist_vld_q & down_i & ~down_q;
    assign both        = up_i & down_i;
    assign active_held = dir_up_q ? up_i : down_i;

    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        step     = 1'b0;
        step_up  = dir_up_q;
        if (both) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (up_edge || down_edge) begin
            step     = 1'b1;
            step_up  = up_edge;
            dir_up_d = up_edge;
            cnt_d    = '0;
            state_d  = DELAY;
        end else begin
            case (state_q)
                DELAY: begin
                    if (!active_held) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DELAY_LAST) begin
                        step    = 1'b1;
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                REPEAT: begin
                    if (!active_held) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == PERIOD_LAST) begin
                        step  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // One extra bit of headroom keeps the limit comparison free of overflow.
    assign g_ext = {gain_q[W-1], gain_q};
    assign g_inc = g_ext + STEP_E;
    assign g_dec = g_ext - STEP_E;

    always_comb begin
        g_next = g_ext;
        if (step_up) begin
            if (g_inc > MAX_E) g_next = (WRAP != 0) ? MIN_E : MAX_E;
            else               g_next = g_inc;
        end else begin
            if (g_dec < MIN_E) g_next = (WRAP != 0) ? MAX_E : MIN_E;
            else               g_next = g_dec;
        end
    end

    assign changed  = step && (g_next[W-1:0] != gain_q);
    // A strobe right after another is deferred through pending so pulses never abut.
    assign pulse_ok = ~busy_i & ~set_q;

    always_comb begin
        gain_d    = changed ? g_next[W-1:0] : gain_q;
        pending_d = pending_q;
        set_d     = 1'b0;
        if ((pending_q || changed) && pulse_ok) begin
            set_d     = 1'b1;
            pending_d = 1'b0;
        end else if (changed) begin
            pending_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dir_up_q   <= 1'b1;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            hist_vld_q <= 1'b0;
            gain_q     <= RESET_G;
            pending_q  <= 1'b0;
            set_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_up_q   <= dir_up_d;
            up_q       <= up_i;
            down_q     <= down_i;
            hist_vld_q <= 1'b1;
            gain_q     <= gain_d;
            pending_q  <= pending_d;
            set_q      <= set_d;
        end
    end

    assign gain_dB_o  = gain_q;
    assign set_gain_o = set_q;
    assign at_min_o   = (gain_q == MIN_G);
    assign at_max_o   = (gain_q == MAX_G);

endmodule

// File: tb/tb_gain_step_control.sv
// Scoreboard bench for gain_step_control: a wrapping and a saturating instance,
// expected strobe gains queued by stimulus and checked by a monitor on each set pulse.
module tb_gain_step_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, up_a, down_a, busy_a;
    logic       rst_b, up_b, down_b, busy_b;
    logic [7:0] gain_a, gain_b;
    logic       set_a, set_b, min_a, max_a, min_b, max_b;

    int n_checks = 0;
    int n_errors = 0;
    int exp_a[$];
    int exp_b[$];
    int pulses_a = 0;
    int pulses_b = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    int p;

    gain_step_control #(
        .W(8), .GAIN_MIN(-16), .GAIN_MAX(44), .GAIN_STEP(4), .GAIN_RESET(0),
        .WRAP(1), .REPEAT_DELAY_CYC(8), .REPEAT_PERIOD_CYC(4)
    ) u_wrap (
        .clk(clk), .rst(rst_a), .up_i(up_a), .down_i(down_a), .busy_i(busy_a),
        .gain_dB_o(gain_a), .set_gain_o(set_a), .at_min_o(min_a), .at_max_o(max_a)
    );

    gain_step_control #(
        .W(8), .GAIN_MIN(-16), .GAIN_MAX(44), .GAIN_STEP(4), .GAIN_RESET(0),
        .WRAP(0), .REPEAT_DELAY_CYC(8), .REPEAT_PERIOD_CYC(4)
    ) u_sat (
        .clk(clk), .rst(rst_b), .up_i(up_b), .down_i(down_b), .busy_i(busy_b),
        .gain_dB_o(gain_b), .set_gain_o(set_b), .at_min_o(min_b), .at_max_o(max_b)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every strobe consumes one queued expected gain.
    always @(negedge clk) begin
        if (set_a === 1'b1) begin
            pulses_a++;
            check("a_no_back_to_back", int'(prev_a), 0);
            if (exp_a.size() == 0) check("a_pulse_expected", 0, 1);
            else check("a_pulse_gain", int'($signed(gain_a)), exp_a.pop_front());
        end
        prev_a = set_a;
        if (set_b === 1'b1) begin
            pulses_b++;
            check("b_no_back_to_back", int'(prev_b), 0);
            if (exp_b.size() == 0) check("b_pulse_expected", 0, 1);
            else check("b_pulse_gain", int'($signed(gain_b)), exp_b.pop_front());
        end
        prev_b = set_b;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_a(input logic dir_up);
        if (dir_up) up_a = 1'b1; else down_a = 1'b1;
        tick(1);
        up_a   = 1'b0;
        down_a = 1'b0;
        tick(2);
    endtask

    task automatic press_b(input logic dir_up);
        if (dir_up) up_b = 1'b1; else down_b = 1'b1;
        tick(1);
        up_b   = 1'b0;
        down_b = 1'b0;
        tick(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; up_a = 1'b0; down_a = 1'b0; busy_a = 1'b0;
        rst_b = 1'b1; up_b = 1'b0; down_b = 1'b0; busy_b = 1'b0;
        tick(3);
        check("reset_gain_a", int'($signed(gain_a)), 0);
        check("reset_set_a", int'(set_a), 0);
        check("reset_min_a", int'(min_a), 0);
        check("reset_max_a", int'(max_a), 0);
        check("reset_gain_b", int'($signed(gain_b)), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick(2);

        // Wrap instance: eleven presses to the top, a twelfth wraps to the bottom.
        for (int i = 1; i <= 11; i++) begin
            exp_a.push_back(4 * i);
            press_a(1'b1);
        end
        check("wrap_gain_top", int'($signed(gain_a)), 44);
        check("wrap_at_max", int'(max_a), 1);
        check("wrap_pulses_11", pulses_a, 11);
        exp_a.push_back(-16);
        press_a(1'b1);
        check("wrap_gain_bottom", int'($signed(gain_a)), -16);
        check("wrap_at_min", int'(min_a), 1);
        check("wrap_pulses_12", pulses_a, 12);

        // Saturating instance: limits hold without a strobe.
        for (int i = 1; i <= 11; i++) begin
            exp_b.push_back(4 * i);
            press_b(1'b1);
        end
        p = pulses_b;
        press_b(1'b1);
        check("sat_gain_top", int'($signed(gain_b)), 44);
        check("sat_top_no_pulse", pulses_b, p);
        for (int i = 1; i <= 15; i++) begin
            exp_b.push_back(44 - 4 * i);
            press_b(1'b0);
        end
        p = pulses_b;
        press_b(1'b0);
        check("sat_gain_bottom", int'($signed(gain_b)), -16);
        check("sat_bottom_no_pulse", pulses_b, p);
        check("sat_at_min", int'(min_b), 1);

        // Auto-repeat: 20-cycle hold steps at edge, +8, +12, +16.
        rst_a = 1'b1;
        tick(2);
        check("rst2_gain", int'($signed(gain_a)), 0);
        rst_a = 1'b0;
        tick(2);
        p = pulses_a;
        exp_a.push_back(4);
        exp_a.push_back(8);
        exp_a.push_back(12);
        exp_a.push_back(16);
        up_a = 1'b1;
        tick(20);
        up_a = 1'b0;
        tick(10);
        check("repeat_gain", int'($signed(gain_a)), 16);
        check("repeat_pulses", pulses_a - p, 4);

        // Busy: three steps coalesce into one deferred strobe.
        rst_a = 1'b1;
        tick(2);
        rst_a = 1'b0;
        tick(2);
        busy_a = 1'b1;
        p = pulses_a;
        press_a(1'b1);
        press_a(1'b1);
        press_a(1'b1);
        check("busy_gain", int'($signed(gain_a)), 12);
        check("busy_no_pulse", pulses_a - p, 0);
        exp_a.push_back(12);
        busy_a = 1'b0;
        tick(3);
        check("busy_flush_pulse", pulses_a - p, 1);
        check("busy_flush_gain", int'($signed(gain_a)), 12);

        // Both buttons together: no step and no repeat.
        p = pulses_a;
        up_a = 1'b1;
        down_a = 1'b1;
        tick(20);
        up_a = 1'b0;
        down_a = 1'b0;
        tick(3);
        check("both_gain", int'($signed(gain_a)), 12);
        check("both_no_pulse", pulses_a - p, 0);

        // Reset mid-repeat with the button still held.
        p = pulses_a;
        exp_a.push_back(16);
        exp_a.push_back(20);
        exp_a.push_back(24);
        up_a = 1'b1;
        tick(14);
        rst_a = 1'b1;
        tick(2);
        check("midrst_gain", int'($signed(gain_a)), 0);
        check("midrst_set", int'(set_a), 0);
        check("midrst_pulses", pulses_a - p, 3);
        rst_a = 1'b0;
        tick(10);
        check("held_after_rst_gain", int'($signed(gain_a)), 0);
        check("held_after_rst_pulses", pulses_a - p, 3);
        up_a = 1'b0;
        tick(2);
        exp_a.push_back(4);
        press_a(1'b1);
        check("repress_gain", int'($signed(gain_a)), 4);
        check("repress_pulses", pulses_a - p, 4);

        check("queue_a_drained", exp_a.size(), 0);
        check("queue_b_drained", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
